au_gray_seq: RTL and testbench
==============================

AU_GRAY_SEQ -- requirements
Module: AU_gray_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 8, word length of sequence values (>= 1).
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request to begin a sequence, sampled only in IDLE.
REQ-005 SHALL have port: stop  input  1  abort request, sampled only in RUN.
REQ-006 SHALL have port: first  input  WIDTH  binary start value, captured on accepted start.
REQ-007 SHALL have port: last  input  WIDTH  binary end value (inclusive), captured on accepted start.
REQ-008 SHALL have port: g  output  WIDTH  Gray-coded current value.
REQ-009 SHALL have port: valid  output  1  g holds a value to transfer.
REQ-010 SHALL have port: ready  input  1  consumer accepts g when valid=1.
REQ-011 SHALL have port: busy  output  1  high while in RUN.
REQ-012 SHALL have port: done  output  1  one-cycle pulse on natural sequence completion.

Function
REQ-013 SHALL implement two states: IDLE and RUN.
REQ-014 In IDLE with start=1, SHALL load the counter with first and the end register with last, then enter RUN on the next edge.
REQ-015 SHALL assert valid and busy from the first cycle after the accepted start; start-to-first-valid latency is 1 cycle.
REQ-016 SHALL drive g = cnt ^ (cnt >> 1), where cnt is the binary counter; g is combinational from registered state only.
REQ-017 Transfer occurs when valid=1 and ready=1; g and valid SHALL hold stable while valid=1 and ready=0.
REQ-018 On transfer with cnt != end, SHALL set cnt to (cnt + 1) mod 2^WIDTH and remain in RUN.
REQ-019 On transfer with cnt == end, SHALL return to IDLE, drop valid and busy next cycle, and pulse done for exactly that cycle.
REQ-020 SHALL wrap from 2^WIDTH-1 to 0 when last < first; the sequence length is ((last - first) mod 2^WIDTH) + 1.
REQ-021 first == last SHALL produce exactly one transfer.
REQ-022 stop=1 in RUN SHALL return to IDLE on the next edge without a done pulse; a transfer in the same cycle still counts as delivered.
REQ-023 stop and cnt == end transfer in the same cycle SHALL be treated as natural completion (done=1).
REQ-024 start in RUN and stop in IDLE SHALL be ignored.
REQ-025 In IDLE, g SHALL reflect the last counter value and valid SHALL be 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, cnt=0, end=0, valid=0, busy=0, done=0, g=0.
REQ-027 Reset asserted mid-sequence SHALL abort it without a done pulse; release SHALL wait for a new start.

Configuration
REQ-028 With AU_GRAY_SEQ_BIN_OUT_EN defined, SHALL add output port b (WIDTH, binary value of cnt, aligned with g); without it, port b SHALL be absent and behaviour otherwise identical.

Structure
REQ-029 SHALL place the state encoding constants (IDLE=0, RUN=1) in shared package AU_gray_seq_pkg.
REQ-030 SHALL compute g with one instance of sub-module AU_bin2gray (WIDTH=WIDTH).
REQ-031 SHALL reject WIDTH < 1 at elaboration with an error message and abort simulation.

Verification
REQ-032 WIDTH=4, first=3, last=6, ready=1 -> g = 2,6,7,5 on consecutive cycles, then done=1 for one cycle, busy=0.
REQ-033 WIDTH=4, first=14, last=1 -> g = 9,8,0,1 (binary 14,15,0,1), done after 4th transfer.
REQ-034 WIDTH=8, first=last=0x80, ready=0 for 5 cycles then 1 -> g=0xC0 held 6 cycles, single transfer, done=1.
REQ-035 WIDTH=4, first=0, last=15, stop=1 after 3 transfers -> IDLE next cycle, done never asserted, start during RUN ignored.
REQ-036 rst_n=0 asserted during RUN at cnt=5 -> outputs zero same cycle, no done; after release, new start first=2 -> g=3 first.

Source files
------------

// File: rtl/au_gray_seq_pkg.sv
// Shared definitions for the Gray-code sequence generator: FSM state encoding.
package au_gray_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/au_bin2gray.sv
// Combinational binary-to-reflected-Gray converter.
module au_bin2gray #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/au_gray_seq.sv
// Gray-coded counting sequence from a captured first value to a captured last value (inclusive).
// Optional binary view of the counter on port b when AU_GRAY_SEQ_BIN_OUT_EN is defined.
module au_gray_seq
    import au_gray_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] g,
`ifdef AU_GRAY_SEQ_BIN_OUT_EN
    output logic [WIDTH-1:0] b,
`endif
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "au_gray_seq: WIDTH must be >= 1");
    end

    // Handshake: a word moves when valid && ready on a rising edge; while valid is
    // high and ready is low, g (and b) hold because cnt only changes on a transfer.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             done_q, done_d;
    logic             xfer;
    logic             at_end;

    assign valid  = (state_q == ST_RUN);
    assign busy   = (state_q == ST_RUN);
    assign done   = done_q;
    assign xfer   = valid && ready;
    assign at_end = (cnt_q == end_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        end_d   = end_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = first;
                    end_d   = last;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Reaching the end wins over a simultaneous stop: that is a natural finish.
                if (xfer && at_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (xfer) begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                    if (stop) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            end_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            done_q  <= done_d;
        end
    end

    au_bin2gray #(
        .WIDTH(WIDTH)
    ) u_bin2gray (
        .bin  (cnt_q),
        .gray (g)
    );

`ifdef AU_GRAY_SEQ_BIN_OUT_EN
    assign b = cnt_q;
`endif

endmodule

// File: tb/tb_au_gray_seq.sv
// Bench for au_gray_seq: a 4-bit instance for sequencing/stop/reset cases, an 8-bit one for the hold case.
module tb_au_gray_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start4 = 0, stop4 = 0, ready4 = 0;
    logic [3:0] first4 = 0, last4 = 0, g4;
    logic       valid4, busy4, done4;

    logic       start8 = 0, stop8 = 0, ready8 = 0;
    logic [7:0] first8 = 0, last8 = 0, g8;
    logic       valid8, busy8, done8;

`ifdef AU_GRAY_SEQ_BIN_OUT_EN
    logic [3:0] b4;
    logic [7:0] b8;
`endif

    int checks = 0;
    int errors = 0;

    // Expected binary words still to be delivered by the current sequence.
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    au_gray_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop4),
        .first(first4), .last(last4), .g(g4),
`ifdef AU_GRAY_SEQ_BIN_OUT_EN
        .b(b4),
`endif
        .valid(valid4), .ready(ready4), .busy(busy4), .done(done4)
    );

    au_gray_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop8),
        .first(first8), .last(last8), .g(g8),
`ifdef AU_GRAY_SEQ_BIN_OUT_EN
        .b(b8),
`endif
        .valid(valid8), .ready(ready8), .busy(busy8), .done(done8)
    );

    function automatic logic [3:0] gray4(input logic [3:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({g4, valid4, busy4, done4} !== 7'd0) begin
            errors++;
            $display("FAIL reset_w4: g=%h valid=%b busy=%b done=%b, required all 0", g4, valid4, busy4, done4);
        end
        checks++;
        if ({g8, valid8, busy8, done8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8: g=%h valid=%b busy=%b done=%b, required all 0", g8, valid8, busy8, done8);
        end
        rst_n = 1'b1;
        stop4 = 1'b1;
        @(negedge clk);
        stop4 = 1'b0;
        checks++;
        if ({g4, valid4, busy4, done4} !== 7'd0) begin
            errors++;
            $display("FAIL idle_after_release: g=%h valid=%b busy=%b done=%b, required all 0", g4, valid4, busy4, done4);
        end
    endtask

    // One full sequence on the 4-bit instance. stop_at < 0 means never stop;
    // otherwise stop is held once that many words have been delivered.
    task automatic run_seq(input logic [3:0] f, input logic [3:0] l, input int stop_at,
                           input int ready_pct, input bit poke_start, input string name);
        logic [3:0] d;
        logic [3:0] cnt_exp;
        int         len, xfers, cycles;
        bit         natural, aborted;
        d = l - f;
        len = int'(d) + 1;
        exp_q.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(f + 4'(i));

        @(negedge clk);
        start4 = 1'b1; first4 = f; last4 = l;
        @(negedge clk);
        start4 = 1'b0; first4 = 4'($urandom); last4 = 4'($urandom);
        xfers = 0; cycles = 0; natural = 0; aborted = 0;

        while (!natural && !aborted && cycles < 300) begin
            checks++;
            if (valid4 !== 1'b1 || busy4 !== 1'b1 || done4 !== 1'b0) begin
                errors++;
                $display("FAIL %s run_flags: valid=%b busy=%b done=%b, required 1 1 0", name, valid4, busy4, done4);
            end
            checks++;
            if (g4 !== gray4(exp_q[0])) begin
                errors++;
                $display("FAIL %s g_word%0d: got %h, required %h", name, xfers, g4, gray4(exp_q[0]));
            end
            ready4 = ($urandom_range(99) < 32'(ready_pct));
            stop4  = (stop_at >= 0 && xfers >= stop_at);
            start4 = poke_start ? 1'($urandom_range(1)) : 1'b0;
            first4 = 4'($urandom); last4 = 4'($urandom);
            @(negedge clk);
            cycles++;
            if (ready4) begin
                void'(exp_q.pop_front());
                xfers++;
                if (exp_q.size() == 0) natural = 1;
            end
            if (!natural && stop4) aborted = 1;
        end
        start4 = 1'b0; stop4 = 1'b0; ready4 = 1'b0;

        if (!natural && !aborted) begin
            checks++; errors++;
            $display("FAIL %s timeout: sequence did not end within %0d cycles", name, cycles);
        end
        cnt_exp = natural ? l : f + 4'(xfers);
        checks++;
        if (done4 !== natural || valid4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL %s end_flags: done=%b valid=%b busy=%b, required %b 0 0", name, done4, valid4, busy4, natural);
        end
        checks++;
        if (g4 !== gray4(cnt_exp)) begin
            errors++;
            $display("FAIL %s idle_g: got %h, required %h", name, g4, gray4(cnt_exp));
        end
        stop4 = 1'b1;
        @(negedge clk);
        stop4 = 1'b0;
        checks++;
        if (done4 !== 1'b0 || valid4 !== 1'b0 || busy4 !== 1'b0 || g4 !== gray4(cnt_exp)) begin
            errors++;
            $display("FAIL %s after_end: done=%b valid=%b busy=%b g=%h, required 0 0 0 %h", name, done4, valid4, busy4, g4, gray4(cnt_exp));
        end
    endtask

    task automatic test_directed();
        run_seq(4'd3,  4'd6,  -1, 100, 1'b0, "seq_3_6");
        run_seq(4'd14, 4'd1,  -1, 100, 1'b0, "wrap_14_1");
        run_seq(4'd9,  4'd9,  -1,  50, 1'b0, "single_9");
        run_seq(4'd0,  4'd15,  3, 100, 1'b1, "stop_after_3");
        run_seq(4'd5,  4'd7,   2, 100, 1'b0, "stop_at_end");
        run_seq(4'd4,  4'd10,  0,   0, 1'b0, "stop_no_xfer");
    endtask

    task automatic test_hold_w8();
        @(negedge clk);
        start8 = 1'b1; first8 = 8'h80; last8 = 8'h80; ready8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (g8 !== 8'hC0 || valid8 !== 1'b1 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL hold_w8 cycle%0d: g=%h valid=%b done=%b, required c0 1 0", i, g8, valid8, done8);
            end
            ready8 = (i == 5);
            @(negedge clk);
        end
        ready8 = 1'b0;
        checks++;
        if (done8 !== 1'b1 || valid8 !== 1'b0 || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_w8 end: done=%b valid=%b busy=%b, required 1 0 0", done8, valid8, busy8);
        end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL hold_w8 done_pulse: done=%b, required 0", done8);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start4 = 1'b1; first4 = 4'd0; last4 = 4'd15;
        @(negedge clk);
        start4 = 1'b0; ready4 = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (g4 !== gray4(4'd5) || valid4 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: g=%h valid=%b, required %h 1", g4, valid4, gray4(4'd5));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({g4, valid4, busy4, done4} !== 7'd0) begin
            errors++;
            $display("FAIL rst_mid async: g=%h valid=%b busy=%b done=%b, required all 0", g4, valid4, busy4, done4);
        end
        ready4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({g4, valid4, busy4, done4} !== 7'd0) begin
            errors++;
            $display("FAIL rst_mid release: g=%h valid=%b busy=%b done=%b, required all 0", g4, valid4, busy4, done4);
        end
        run_seq(4'd2, 4'd3, -1, 100, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int sa;
            sa = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(15));
            run_seq(4'($urandom), 4'($urandom), sa, int'($urandom_range(30, 100)), 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_w8();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
